// File: rtl/trav_pkg.sv
// Shared types for the traversal scheduler: request/result records, the split-case
// encoding and the trav_math flag classifier.
package trav_pkg;

    localparam int TRAV_MATH_LAT = 14;
    localparam int TRAV_TAG_W    = 8;
    localparam int TRAV_SRC_W    = 3;

    typedef logic [31:0] float_t;

    typedef enum logic [1:0] {
        ONLY_LO = 2'd0,
        ONLY_HI = 2'd1,
        LO_HI   = 2'd2,
        HI_LO   = 2'd3
    } trav_case_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_FLUSHED = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [TRAV_TAG_W-1:0] tag;
        float_t                origin;
        float_t                dir;
        float_t                split;
        float_t                t_max;
        float_t                t_min;
    } trav_req_t;

    typedef struct packed {
        logic [TRAV_TAG_W-1:0] tag;
        logic [TRAV_SRC_W-1:0] src;
        float_t                t_max;
        float_t                t_min;
        float_t                t_mid;
        trav_case_t            trav_case;
        logic                  err;
    } trav_res_t;

    typedef struct packed {
        trav_case_t trav_case;
        logic       err;
    } trav_cls_t;

    // Anything other than exactly one flag (e.g. NaN inputs) is an error with case 0.
    function automatic trav_cls_t trav_classify(input logic only_lo, input logic only_hi,
                                                input logic lo_hi, input logic hi_lo);
        trav_cls_t c;
        c.err       = 1'b0;
        c.trav_case = ONLY_LO;
        case ({only_lo, only_hi, lo_hi, hi_lo})
            4'b1000: c.trav_case = ONLY_LO;
            4'b0100: c.trav_case = ONLY_HI;
            4'b0010: c.trav_case = LO_HI;
            4'b0001: c.trav_case = HI_LO;
            default: c.err       = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/trav_sched_chk.sv
// Assertion checker for trav_sched: the credit scheme must keep the result FIFO from
// ever being pushed while full.
module trav_sched_chk #(
    parameter int CNT_W      = 5,
    parameter int FIFO_DEPTH = 16
) (
    input logic             clk,
    input logic             rst,
    input logic             push_i,
    input logic             full_i,
    input logic [CNT_W-1:0] credit_i
);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
                                     credit_i <= CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/trav_sched_rr_arb.sv
// Generic round-robin arbiter: one-hot grant searched from a rotating pointer that
// advances past the winner only when the grant is actually taken.
module rr_arb #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found_s;

    // First requester at or after the pointer wins.
    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found_s && req_i[cand]) begin
                found_s       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer next-state.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found_s) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/trav_sched.sv
// Shares one fixed-latency trav_math pipe between N_REQ requesters with a credit-guarded
// result FIFO. Optional counters: define TRAV_SCHED_STATS_EN.
module trav_sched
    import trav_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int MATH_LAT   = TRAV_MATH_LAT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ*$bits(trav_req_t)-1:0] req_data,
    input  logic                              flush,
    output logic                              flushed,
    output float_t                            math_origin,
    output float_t                            math_dir,
    output float_t                            math_split,
    output float_t                            math_t_max,
    output float_t                            math_t_min,
    input  float_t                            math_t_max_in,
    input  float_t                            math_t_min_in,
    input  float_t                            math_t_mid_in,
    input  logic                              math_only_low,
    input  logic                              math_only_high,
    input  logic                              math_lo_hi,
    input  logic                              math_hi_lo,
    output logic                              res_valid,
    input  logic                              res_ready,
    output trav_res_t                         res_data
`ifdef TRAV_SCHED_STATS_EN
    ,
    output logic [31:0]                       stat_issued,
    output logic [31:0]                       stat_credit_stall,
    output logic [15:0]                       stat_err
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int REQ_W = $bits(trav_req_t);

    sched_state_t          state_q, state_d;
    logic [CNT_W-1:0]      credit_q, credit_d, count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MATH_LAT-1:0]   vld_q;
    logic [TRAV_TAG_W-1:0] tag_q [MATH_LAT];
    logic [TRAV_SRC_W-1:0] src_q [MATH_LAT];
    trav_res_t             mem_q [FIFO_DEPTH];

    logic                  issue_s, push_s, pop_s, full_s;
    logic [N_REQ-1:0]      grant_s;
    logic [IDX_W-1:0]      grant_idx_s;
    trav_req_t             sel_req_s;
    trav_cls_t             cls_s;
    trav_res_t             push_data_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A flush request blocks issue in the very cycle it is first seen.
    assign issue_s = !rst && (state_q == ST_RUN) && !flush && (|req_valid) && (credit_q != '0);

    rr_arb #(.N(N_REQ), .IW(IDX_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .advance_i (issue_s),
        .grant_o   (grant_s),
        .idx_o     (grant_idx_s)
    );

    assign req_ready   = issue_s ? grant_s : '0;
    assign sel_req_s   = trav_req_t'(req_data[int'(grant_idx_s)*REQ_W +: REQ_W]);
    assign math_origin = sel_req_s.origin;
    assign math_dir    = sel_req_s.dir;
    assign math_split  = sel_req_s.split;
    assign math_t_max  = sel_req_s.t_max;
    assign math_t_min  = sel_req_s.t_min;

    // Tag pipe valids: only these are reset, so stale math results are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[MATH_LAT-2:0], issue_s};
        end
    end

    // Tag/source shift register travelling alongside the math pipe.
    always_ff @(posedge clk) begin
        tag_q[0] <= sel_req_s.tag;
        src_q[0] <= TRAV_SRC_W'(grant_idx_s);
        for (int k = 1; k < MATH_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
            src_q[k] <= src_q[k-1];
        end
    end

    assign push_s = vld_q[MATH_LAT-1];
    assign pop_s  = (count_q != '0) && res_ready;
    assign full_s = (count_q == CNT_W'(FIFO_DEPTH));
    assign cls_s  = trav_classify(math_only_low, math_only_high, math_lo_hi, math_hi_lo);

    // Re-join the emerging math result with its tag.
    always_comb begin
        push_data_s.tag       = tag_q[MATH_LAT-1];
        push_data_s.src       = src_q[MATH_LAT-1];
        push_data_s.t_max     = math_t_max_in;
        push_data_s.t_min     = math_t_min_in;
        push_data_s.t_mid     = math_t_mid_in;
        push_data_s.trav_case = cls_s.trav_case;
        push_data_s.err       = cls_s.err;
    end

    // FIFO pointers, occupancy and credit next-state.
    always_comb begin
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({issue_s, pop_s})
            2'b10:   credit_d = credit_q - CNT_W'(1);
            2'b01:   credit_d = credit_q + CNT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_s;
        end
    end

    assign res_valid = (count_q != '0);
    assign res_data  = mem_q[rd_ptr_q];

    // Flush state machine next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                state_d = flush ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                if (!flush) begin
                    state_d = ST_RUN;
                end else if ((vld_q == '0) && (count_q == '0)) begin
                    state_d = ST_FLUSHED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSHED: begin
                state_d = flush ? ST_FLUSHED : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign flushed = (state_q == ST_FLUSHED);

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            credit_q <= CNT_W'(FIFO_DEPTH);
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    trav_sched_chk #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push_s),
        .full_i   (full_s),
        .credit_i (credit_q)
    );

`ifdef TRAV_SCHED_STATS_EN
    logic [31:0] issued_q, stall_q;
    logic [15:0] err_q;
    logic        stall_s;

    assign stall_s = (|req_valid) && (state_q == ST_RUN) && (credit_q == '0);

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= 32'd0;
            stall_q  <= 32'd0;
            err_q    <= 16'd0;
        end else begin
            if (issue_s && (issued_q != 32'hFFFF_FFFF)) begin
                issued_q <= issued_q + 32'd1;
            end
            if (stall_s && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (push_s && cls_s.err && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign stat_issued       = issued_q;
    assign stat_credit_stall = stall_q;
    assign stat_err          = err_q;
`endif

endmodule

// File: tb/tb_trav_sched.sv
// Directed bench for trav_sched with a behavioural 14-cycle trav_math model whose flags
// come from origin[3:0] = {only_low, only_high, lo_hi, hi_lo}.
module tb_trav_sched;
    import trav_pkg::*;

    localparam int N   = 3;
    localparam int LAT = 14;

    logic              clk = 1'b0;
    logic              rst, flush, flushed, res_valid, res_ready;
    logic [N-1:0]      req_valid, req_ready;
    logic [N*$bits(trav_req_t)-1:0] req_data;
    float_t            math_origin, math_dir, math_split, math_t_max, math_t_min;
    float_t            math_t_max_in, math_t_min_in, math_t_mid_in;
    logic              math_only_low, math_only_high, math_lo_hi, math_hi_lo;
    trav_res_t         res_data;
`ifdef TRAV_SCHED_STATS_EN
    logic [31:0]       stat_issued, stat_credit_stall;
    logic [15:0]       stat_err;
`endif

    trav_req_t         reqs [N];
    float_t            pm_max [LAT], pm_min [LAT], pm_mid [LAT];
    logic [3:0]        pm_fl [LAT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         src;
        logic [7:0] tag;
        logic [3:0] flags;
        logic [1:0] exp_case;
        logic       exp_err;
    } vec_t;

    vec_t        vecs [6];
    logic [10:0] exp_q [$];

    always #5 clk = ~clk;

    assign req_data = {reqs[2], reqs[1], reqs[0]};

    trav_sched dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .flush          (flush),
        .flushed        (flushed),
        .math_origin    (math_origin),
        .math_dir       (math_dir),
        .math_split     (math_split),
        .math_t_max     (math_t_max),
        .math_t_min     (math_t_min),
        .math_t_max_in  (math_t_max_in),
        .math_t_min_in  (math_t_min_in),
        .math_t_mid_in  (math_t_mid_in),
        .math_only_low  (math_only_low),
        .math_only_high (math_only_high),
        .math_lo_hi     (math_lo_hi),
        .math_hi_lo     (math_hi_lo),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data)
`ifdef TRAV_SCHED_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_credit_stall (stat_credit_stall),
        .stat_err          (stat_err)
`endif
    );

    // trav_math stand-in: pure delay of the issued operands.
    always @(posedge clk) begin
        pm_max[0] <= math_t_max;
        pm_min[0] <= math_t_min;
        pm_mid[0] <= math_split;
        pm_fl[0]  <= math_origin[3:0];
        for (int k = 1; k < LAT; k++) begin
            pm_max[k] <= pm_max[k-1];
            pm_min[k] <= pm_min[k-1];
            pm_mid[k] <= pm_mid[k-1];
            pm_fl[k]  <= pm_fl[k-1];
        end
    end

    assign math_t_max_in  = pm_max[LAT-1];
    assign math_t_min_in  = pm_min[LAT-1];
    assign math_t_mid_in  = pm_mid[LAT-1];
    assign math_only_low  = pm_fl[LAT-1][3];
    assign math_only_high = pm_fl[LAT-1][2];
    assign math_lo_hi     = pm_fl[LAT-1][1];
    assign math_hi_lo     = pm_fl[LAT-1][0];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int r, input logic [7:0] tag, input logic [3:0] fl, input int seq);
        reqs[r].tag    = tag;
        reqs[r].origin = {28'h0, fl};
        reqs[r].dir    = 32'h3F80_0000;
        reqs[r].split  = 32'h4100_0000 + 32'(seq);
        reqs[r].t_max  = 32'h4200_0000 + 32'(seq);
        reqs[r].t_min  = 32'h4000_0000 + 32'(seq);
    endtask

    // Pops everything that shows up within the budget, comparing {tag,src} in order.
    task automatic drain(input string nm, input int budget, output int got);
        got = 0;
        res_ready = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (res_valid) begin
                if (exp_q.size() > 0) begin
                    chk(nm, {res_data.tag, res_data.src}, exp_q.pop_front());
                end
                got++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int wait_k, got, nissue, bad, grants, pops, seen;

        vecs[0] = '{src: 1, tag: 8'h12, flags: 4'b0100, exp_case: 2'd1, exp_err: 1'b0};
        vecs[1] = '{src: 0, tag: 8'hA5, flags: 4'b1000, exp_case: 2'd0, exp_err: 1'b0};
        vecs[2] = '{src: 2, tag: 8'h3C, flags: 4'b0010, exp_case: 2'd2, exp_err: 1'b0};
        vecs[3] = '{src: 1, tag: 8'h77, flags: 4'b0001, exp_case: 2'd3, exp_err: 1'b0};
        vecs[4] = '{src: 0, tag: 8'h01, flags: 4'b0000, exp_case: 2'd0, exp_err: 1'b1};
        vecs[5] = '{src: 2, tag: 8'hFE, flags: 4'b1010, exp_case: 2'd0, exp_err: 1'b1};

        for (int r = 0; r < N; r++) set_req(r, 8'h00, 4'b1000, 0);
        rst = 1'b1; flush = 1'b0; res_ready = 1'b0; req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_flushed", flushed, 1'b0);
`ifdef TRAV_SCHED_STATS_EN
        chk("rst_stat_issued", stat_issued, 32'd0);
`endif
        rst = 1'b0; req_valid = '0;

        // Single-request vectors: latency, tag, source, case and error flag.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req(vecs[i].src, vecs[i].tag, vecs[i].flags, i);
            req_valid = oh(vecs[i].src);
            #1 chk("vec_grant", req_ready, oh(vecs[i].src));
            wait_k = 0;
            for (int k = 1; k <= LAT + 6; k++) begin
                @(negedge clk);
                if (k == 1) req_valid = '0;
                if (res_valid) begin
                    wait_k = k;
                    break;
                end
            end
            chk("vec_latency", wait_k, LAT + 1);
            chk("vec_tag", res_data.tag, vecs[i].tag);
            chk("vec_src", res_data.src, 3'(vecs[i].src));
            chk("vec_case", res_data.trav_case, vecs[i].exp_case);
            chk("vec_err", res_data.err, vecs[i].exp_err);
            chk("vec_t", {res_data.t_max, res_data.t_min},
                {32'h4200_0000 + 32'(i), 32'h4000_0000 + 32'(i)});
            chk("vec_mid", res_data.t_mid, 32'h4100_0000 + 32'(i));
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("vec_popped", res_valid, 1'b0);
        end
`ifdef TRAV_SCHED_STATS_EN
        chk("stat_err", stat_err, 16'd2);
`endif

        // All requesters valid: grants rotate 0,1,2 and results stay in issue order.
        res_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            for (int r = 0; r < N; r++) set_req(r, {i[3:0], r[3:0]}, 4'b1000, 100 + i);
            req_valid = '1;
            #1 chk("rr_grant", req_ready, oh(i % 3));
            exp_q.push_back({i[3:0], 4'(i % 3), 3'(i % 3)});
        end
        @(negedge clk);
        req_valid = '0;
        drain("rr_order", 40, got);
        chk("rr_count", got, 9);
        exp_q.delete();

        // Reset with 7 in flight: nothing may emerge afterwards.
        res_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_valid = '1;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1; req_valid = '1;
        #1 chk("rst_gate_ready", req_ready, 3'b000);
        @(negedge clk);
        chk("rst2_res_valid", res_valid, 1'b0);
        rst = 1'b0; req_valid = '0;
        bad = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        chk("rst_no_result", bad, 0);

        // Backpressure: exactly FIFO_DEPTH issues, then issue stalls.
        nissue = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            for (int r = 0; r < N; r++) set_req(r, 8'(i * 4 + r), 4'b0100, 200 + i);
            req_valid = '1;
            #1;
            if (req_ready != '0) begin
                chk("stall_grant", req_ready, oh(nissue % 3));
                exp_q.push_back({8'(i * 4 + nissue % 3), 3'(nissue % 3)});
                nissue++;
            end
        end
        chk("stall_issues", nissue, 16);
        @(negedge clk);
        #1 chk("stall_hold", req_ready, 3'b000);
        req_valid = '0;
        chk("stall_res_valid", res_valid, 1'b1);
        if (exp_q.size() > 0) chk("stall_head", {res_data.tag, res_data.src}, exp_q[0]);
`ifdef TRAV_SCHED_STATS_EN
        chk("stat_credit_stall", stat_credit_stall, 32'd9);
        chk("stat_issued", stat_issued, 32'd16);
`endif
        @(negedge clk);
        drain("stall_order", 60, got);
        chk("stall_drained", got, 16);
        req_valid = '1;
        #1 chk("stall_resume", req_ready, oh(1));
        req_valid = '0;

        // Flush with 5 in flight: no grants, flushed after the last pop, then resume.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int r = 0; r < N; r++) set_req(r, 8'(128 + i * 4 + r), 4'b0001, 300 + i);
            req_valid = '1;
            #1 chk("fl_grant", req_ready, oh((i + 1) % 3));
        end
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_block", req_ready, 3'b000);
        grants = 0; pops = 0; seen = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (req_ready != '0) grants++;
            if (flushed) begin
                seen = 1;
                break;
            end
            if (res_valid) pops++;
            @(negedge clk);
        end
        chk("fl_grants", grants, 0);
        chk("fl_pops", pops, 5);
        chk("fl_flushed", seen, 1);
        flush = 1'b0;
        #1 chk("fl_still_blocked", req_ready, 3'b000);
        @(negedge clk);
        #1 chk("fl_resume", req_ready, oh(0));
        chk("fl_flushed_low", flushed, 1'b0);
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
